// File: rtl/ryu_pkg.sv
// Shared types and screen geometry for the Ryu sprite pipeline.
// Included by the motion controller and the renderers.
package ryu_pkg;

    typedef enum logic [1:0] {GROUND, AIR, LAND} ryu_motion_t;

    localparam int SPRITE_W = 108;
    localparam int SPRITE_H = 144;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/ryu_jump_motion_if.sv
// Frame inputs (vsync, keys) and registered sprite placement outputs of the motion controller.
// master drives keys/vsync; slave is the controller.
interface ryu_jump_motion_if;

    logic       vsync;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic [9:0] RyuX;
    logic [9:0] RyuY;
    logic       jump_active;
    logic       landed;

    modport master (
        output vsync, key_left, key_right, key_jump,
        input  RyuX, RyuY, jump_active, landed
    );

    modport slave (
        input  vsync, key_left, key_right, key_jump,
        output RyuX, RyuY, jump_active, landed
    );

endinterface

// File: rtl/ryu_jump_motion_vsync_edge_detect.sv
// Frame tick from the vsync falling edge; tick is combinational off the registered vsync.
// Latency 0 from the low vsync sample, no backpressure.
module vsync_edge_detect (
    input  logic vga_clk,
    input  logic Reset,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;
    logic vsync_d;

    always_comb vsync_d = vsync;

    // Reset to 1 so a vsync already low out of reset still yields one tick.
    always_ff @(posedge vga_clk) begin
        if (Reset) vsync_q <= 1'b1;
        else       vsync_q <= vsync_d;
    end

    assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/ryu_jump_motion.sv
// Per-frame position and jump physics for Ryu; outputs registered, 1 vga_clk after the vsync fall.
// No backpressure: keys are levels sampled on each frame tick.
module ryu_jump_motion #(
    parameter int START_X   = 100,
    parameter int GROUND_Y  = 300,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 532,
    parameter int WALK_STEP = 3,
    parameter int JUMP_V0   = 16,
    parameter int GRAVITY   = 1
) (
    input  logic               vga_clk,
    input  logic               Reset,
    ryu_jump_motion_if.slave   io
);
    import ryu_pkg::*;

    localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
    localparam logic signed [10:0] STEP_S     = 11'(WALK_STEP);
    localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);
    localparam logic signed [7:0]  VY_TAKEOFF = 8'(-JUMP_V0);
    localparam logic signed [8:0]  GRAVITY_S  = 9'(GRAVITY);

    logic tick;

    vsync_edge_detect u_vsync_edge (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .vsync   (io.vsync),
        .tick    (tick)
    );

    ryu_motion_t        state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [7:0]  vy_q, vy_d;
    logic [1:0]         air_dir_q, air_dir_d;
    logic               jump_active_q, jump_active_d;
    logic               landed_q, landed_d;

    logic               walk_l, walk_r;
    logic signed [10:0] x_wide;
    logic [9:0]         x_walk;
    logic signed [10:0] next_y;
    logic signed [8:0]  vy_sum;
    logic signed [7:0]  vy_sat;

    // Airborne motion follows the direction latched at takeoff, not the live keys.
    always_comb begin
        walk_l = io.key_left;
        walk_r = io.key_right;
        if (state_q == AIR) begin
            walk_l = air_dir_q[1];
            walk_r = air_dir_q[0];
        end
        x_wide = $signed({1'b0, x_q});
        if (walk_l & ~walk_r)      x_wide = x_wide - STEP_S;
        else if (walk_r & ~walk_l) x_wide = x_wide + STEP_S;
        if (x_wide < X_MIN_S)      x_walk = X_MIN_S[9:0];
        else if (x_wide > X_MAX_S) x_walk = X_MAX_S[9:0];
        else                       x_walk = x_wide[9:0];
    end

    always_comb begin
        next_y = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
        vy_sum = $signed({vy_q[7], vy_q}) + GRAVITY_S;
        if (vy_sum > 9'sd127)       vy_sat = 8'sd127;
        else if (vy_sum < -9'sd128) vy_sat = -8'sd128;
        else                        vy_sat = vy_sum[7:0];
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        vy_d          = vy_q;
        air_dir_d     = air_dir_q;
        jump_active_d = jump_active_q;
        landed_d      = 1'b0;
        if (tick) begin
            case (state_q)
                GROUND: begin
                    if (io.key_jump) begin
                        vy_d          = VY_TAKEOFF;
                        air_dir_d     = {io.key_left, io.key_right};
                        state_d       = AIR;
                        jump_active_d = 1'b1;
                    end else begin
                        x_d = x_walk;
                    end
                end
                AIR: begin
                    x_d  = x_walk;
                    vy_d = vy_sat;
                    if (next_y < 11'sd0) begin
                        y_d  = '0;
                        vy_d = '0;
                    end else if (!vy_q[7] && next_y >= GROUND_Y_S) begin
                        y_d           = GROUND_Y_S[9:0];
                        vy_d          = '0;
                        state_d       = LAND;
                        jump_active_d = 1'b0;
                        landed_d      = 1'b1;
                    end else begin
                        y_d = next_y[9:0];
                    end
                end
                LAND: begin
                    x_d     = x_walk;
                    state_d = GROUND;
                end
                default: state_d = GROUND;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q       <= GROUND;
            x_q           <= 10'(START_X);
            y_q           <= 10'(GROUND_Y);
            vy_q          <= '0;
            air_dir_q     <= '0;
            jump_active_q <= 1'b0;
            landed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            vy_q          <= vy_d;
            air_dir_q     <= air_dir_d;
            jump_active_q <= jump_active_d;
            landed_q      <= landed_d;
        end
    end

    assign io.RyuX        = x_q;
    assign io.RyuY        = y_q;
    assign io.jump_active = jump_active_q;
    assign io.landed      = landed_q;

endmodule
